// File: rtl/wb_ctrl.sv
// Write-buffer sequencing controller for the D-cache store path.
// Allocates or merges CPU stores into a 4-line x 2-word buffer, evicts a line
// on a tag conflict, and drains the buffer to memory on request or when full.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | accept stores, or start a drain-all when requested / full
// S_RD    | read one word of line L, latch it for the memory write
// S_MW    | memory write in flight, waiting for mem_ack
// S_WSKIP | word had no valid bytes, advance without a memory write
// S_CLR   | flush line L (tag-valid and byte-valids cleared)
// S_NEXT  | drain-all: step to the next line or finish
module wb_ctrl #(
   parameter int MEM_AW = 32,
   parameter int NLINES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                st_req,
   input  logic [MEM_AW-1:0]   st_addr,
   input  logic [3:0]          st_mbe,
   output logic                st_ack,
   input  logic                drain_req,
   output logic                drain_done,
   output logic                wb_empty,
   output logic                wb_ten,
   output logic                wb_tven,
   output logic                wb_ven,
   output logic                wb_men,
   output logic                wb_rd,
   output logic                wb_wr,
   output logic                wb_fl,
   output logic [MEM_AW-1:0]   wb_a,
   output logic [3:0]          wb_mbe,
   output logic                wb_tv_in,
   input  logic                wb_tv_out,
   input  logic                wb_tmatch,
   input  logic                wb_full,
   input  logic [MEM_AW-6:0]   wb_tag,
   input  logic [31:0]         wb_rdata,
   input  logic [3:0]          wb_dvalid,
   output logic                mem_req,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   output logic [3:0]          mem_be,
   input  logic                mem_ack
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD    = 3'd1;
   localparam logic [2:0] S_MW    = 3'd2;
   localparam logic [2:0] S_WSKIP = 3'd3;
   localparam logic [2:0] S_CLR   = 3'd4;
   localparam logic [2:0] S_NEXT  = 3'd5;

   localparam logic [2:0] MAX_CNT = 3'(NLINES);

   logic [2:0] state;
   logic [1:0] line;
   logic       word;
   logic       mode_all;
   logic [2:0] occ_cnt;

   logic       start_drain;
   logic       conflict;
   logic       alloc;
   logic [MEM_AW-1:0] rd_addr;

   assign rd_addr  = {wb_tag, line, word, 2'b00};
   assign wb_empty = (occ_cnt == 3'd0);

   // Buffer controls, handshake pulses and IDLE decisions; reads are combinational.
   always_comb begin
      st_ack      = 1'b0;
      drain_done  = 1'b0;
      mem_req     = 1'b0;
      wb_ten      = 1'b0;
      wb_tven     = 1'b0;
      wb_ven      = 1'b0;
      wb_men      = 1'b0;
      wb_rd       = 1'b0;
      wb_wr       = 1'b0;
      wb_fl       = 1'b0;
      wb_tv_in    = 1'b0;
      wb_a        = '0;
      wb_mbe      = 4'h0;
      start_drain = 1'b0;
      conflict    = 1'b0;
      alloc       = 1'b0;
      case (state)
         S_IDLE: begin
            // Gated by rst so nothing leaks out during the reset cycle.
            if (!rst) begin
               if (drain_req || wb_full) begin
                  start_drain = 1'b1;
               end else if (st_req) begin
                  wb_a   = st_addr;
                  wb_mbe = st_mbe;
                  if (!wb_tv_out || wb_tmatch) begin
                     wb_ten   = 1'b1;
                     wb_tven  = 1'b1;
                     wb_ven   = 1'b1;
                     wb_men   = 1'b1;
                     wb_wr    = 1'b1;
                     wb_tv_in = 1'b1;
                     st_ack   = 1'b1;
                     alloc    = !wb_tv_out;
                  end else begin
                     conflict = 1'b1;
                  end
               end
            end
         end
         S_RD: begin
            wb_a   = rd_addr;
            wb_rd  = 1'b1;
            wb_men = 1'b1;
            wb_mbe = 4'hf;
         end
         S_MW: begin
            mem_req = 1'b1;
         end
         S_CLR: begin
            wb_a    = {{(MEM_AW-5){1'b0}}, line, 3'b000};
            wb_fl   = 1'b1;
            wb_wr   = 1'b1;
            wb_ven  = 1'b1;
            wb_tven = 1'b1;
         end
         S_NEXT: begin
            drain_done = (line == 2'd3);
         end
         default: ;
      endcase
   end

   // Sequencer, line/word pointers, occupancy and the latched memory write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         line      <= 2'd0;
         word      <= 1'b0;
         mode_all  <= 1'b0;
         occ_cnt   <= 3'd0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
         mem_be    <= 4'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_drain) begin
                  line     <= 2'd0;
                  word     <= 1'b0;
                  mode_all <= 1'b1;
                  state    <= S_RD;
               end else if (conflict) begin
                  line     <= st_addr[4:3];
                  word     <= 1'b0;
                  mode_all <= 1'b0;
                  state    <= S_RD;
               end else if (alloc && (occ_cnt < MAX_CNT)) begin
                  occ_cnt <= occ_cnt + 3'd1;
               end
            end
            S_RD: begin
               mem_addr  <= rd_addr;
               mem_wdata <= wb_rdata;
               mem_be    <= wb_dvalid;
               if (mode_all && !wb_tv_out) begin
                  state <= S_NEXT;
               end else if (wb_dvalid == 4'h0) begin
                  state <= S_WSKIP;
               end else begin
                  state <= S_MW;
               end
            end
            S_MW, S_WSKIP: begin
               if (state == S_WSKIP || mem_ack) begin
                  if (!word) begin
                     word  <= 1'b1;
                     state <= S_RD;
                  end else begin
                     state <= S_CLR;
                  end
               end
            end
            S_CLR: begin
               if (occ_cnt != 3'd0) begin
                  occ_cnt <= occ_cnt - 3'd1;
               end
               state <= mode_all ? S_NEXT : S_IDLE;
            end
            S_NEXT: begin
               if (line == 2'd3) begin
                  state <= S_IDLE;
               end else begin
                  line  <= line + 2'd1;
                  word  <= 1'b0;
                  state <= S_RD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: a behavioural write-buffer array answers the controller's
// combinational reads, a memory responder acks writes after a chosen delay,
// and a per-store line model predicts every memory write and the occupancy.
module tb_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_req;
   logic [31:0] st_addr;
   logic [3:0]  st_mbe;
   logic        st_ack;
   logic        drain_req;
   logic        drain_done;
   logic        wb_empty;
   logic        wb_ten, wb_tven, wb_ven, wb_men, wb_rd, wb_wr, wb_fl;
   logic [31:0] wb_a;
   logic [3:0]  wb_mbe;
   logic        wb_tv_in;
   logic        wb_tv_out;
   logic        wb_tmatch;
   logic        wb_full;
   logic [26:0] wb_tag;
   logic [31:0] wb_rdata;
   logic [3:0]  wb_dvalid;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;

   logic [31:0] st_data;
   int          ack_wait;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   wb_ctrl #(.MEM_AW(32), .NLINES(4)) dut (
      .clk(clk), .rst(rst),
      .st_req(st_req), .st_addr(st_addr), .st_mbe(st_mbe), .st_ack(st_ack),
      .drain_req(drain_req), .drain_done(drain_done), .wb_empty(wb_empty),
      .wb_ten(wb_ten), .wb_tven(wb_tven), .wb_ven(wb_ven), .wb_men(wb_men),
      .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_fl(wb_fl), .wb_a(wb_a), .wb_mbe(wb_mbe),
      .wb_tv_in(wb_tv_in), .wb_tv_out(wb_tv_out), .wb_tmatch(wb_tmatch),
      .wb_full(wb_full), .wb_tag(wb_tag), .wb_rdata(wb_rdata), .wb_dvalid(wb_dvalid),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack)
   );

   // ---------------- write buffer array ----------------
   logic [26:0] b_tag [4];
   logic        b_tv  [4];
   logic [3:0]  b_bv  [4][2];
   logic [31:0] b_dat [4][2];
   logic [1:0]  bl;
   logic        bw;

   assign bl        = wb_a[4:3];
   assign bw        = wb_a[2];
   assign wb_tv_out = b_tv[bl];
   assign wb_tag    = b_tag[bl];
   assign wb_tmatch = (b_tag[bl] == wb_a[31:5]);
   assign wb_rdata  = b_dat[bl][bw];
   assign wb_dvalid = b_bv[bl][bw];

   always_comb begin
      wb_full = 1'b1;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 2; j++)
            if (b_bv[i][j] != 4'hf) wb_full = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            b_tag[i] <= '0;
            b_tv[i]  <= 1'b0;
            for (int j = 0; j < 2; j++) begin
               b_bv[i][j]  <= 4'h0;
               b_dat[i][j] <= 32'h0;
            end
         end
      end else if (wb_wr && wb_fl) begin
         b_tv[bl]     <= wb_tv_in;
         b_bv[bl][0]  <= 4'h0;
         b_bv[bl][1]  <= 4'h0;
         b_dat[bl][0] <= 32'h0;
         b_dat[bl][1] <= 32'h0;
      end else if (wb_wr && wb_men) begin
         b_tag[bl]    <= wb_a[31:5];
         b_tv[bl]     <= wb_tv_in;
         b_bv[bl][bw] <= b_bv[bl][bw] | wb_mbe;
         for (int k = 0; k < 4; k++)
            if (wb_mbe[k]) b_dat[bl][bw][8*k +: 8] <= st_data[8*k +: 8];
      end
   end

   // ---------------- memory responder ----------------
   logic [67:0] act_q[$];
   int          act_idx = 0;

   initial begin
      int  wcnt;
      bit  pend;
      mem_ack = 1'b0;
      pend    = 1'b0;
      wcnt    = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            mem_ack = 1'b0;
            pend    = 1'b0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            pend    = 1'b0;
         end else if (mem_req) begin
            if (!pend) begin
               pend = 1'b1;
               wcnt = ack_wait;
            end
            if (wcnt == 0) begin
               mem_ack = 1'b1;
               act_q.push_back({mem_addr, mem_wdata, mem_be});
            end else begin
               wcnt--;
            end
         end
      end
   end

   // ---------------- reference model: lines as whole objects ----------------
   bit          r_valid [4];
   logic [26:0] r_tag   [4];
   logic [3:0]  r_be    [4][2];
   logic [31:0] r_dat   [4][2];
   logic [67:0] exp_q[$];
   int          exp_idx = 0;

   function automatic void ref_clear();
      for (int l = 0; l < 4; l++) begin
         r_valid[l] = 1'b0;
         r_tag[l]   = '0;
         for (int w = 0; w < 2; w++) begin
            r_be[l][w]  = 4'h0;
            r_dat[l][w] = 32'h0;
         end
      end
   endfunction

   // A line leaves the buffer as one memory write per word holding any valid byte.
   function automatic void ref_evict(input int l);
      logic [31:0] a;
      for (int w = 0; w < 2; w++) begin
         if (r_be[l][w] != 4'h0) begin
            a = {r_tag[l], 5'b0} + 32'(l * 8 + w * 4);
            exp_q.push_back({a, r_dat[l][w], r_be[l][w]});
         end
         r_be[l][w]  = 4'h0;
         r_dat[l][w] = 32'h0;
      end
      r_valid[l] = 1'b0;
   endfunction

   function automatic void ref_drain();
      for (int l = 0; l < 4; l++)
         if (r_valid[l]) ref_evict(l);
   endfunction

   function automatic void ref_store(input logic [31:0] a, input logic [3:0] m,
                                     input logic [31:0] d);
      int l;
      int w;
      l = int'(a[4:3]);
      w = int'(a[2]);
      if (r_valid[l] && r_tag[l] != a[31:5]) ref_evict(l);
      r_valid[l] = 1'b1;
      r_tag[l]   = a[31:5];
      r_be[l][w] = r_be[l][w] | m;
      for (int k = 0; k < 4; k++)
         if (m[k]) r_dat[l][w][8*k +: 8] = d[8*k +: 8];
   endfunction

   function automatic int ref_count();
      int c = 0;
      for (int l = 0; l < 4; l++) if (r_valid[l]) c++;
      return c;
   endfunction

   function automatic bit ref_full();
      bit f = 1'b1;
      for (int l = 0; l < 4; l++)
         for (int w = 0; w < 2; w++)
            if (r_be[l][w] != 4'hf) f = 1'b0;
      return f;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_writes(input string tag);
      logic [67:0] a;
      logic [67:0] e;
      logic [31:0] msk;
      chk({tag, "_nwrites"}, 64'(act_q.size() - act_idx), 64'(exp_q.size() - exp_idx));
      while (act_idx < act_q.size() && exp_idx < exp_q.size()) begin
         a = act_q[act_idx];
         e = exp_q[exp_idx];
         msk = {{8{e[3]}}, {8{e[2]}}, {8{e[1]}}, {8{e[0]}}};
         chk({tag, "_addr"}, 64'(a[67:36]), 64'(e[67:36]));
         chk({tag, "_be"},   64'(a[3:0]),   64'(e[3:0]));
         chk({tag, "_data"}, 64'(a[35:4] & msk), 64'(e[35:4] & msk));
         act_idx++;
         exp_idx++;
      end
      act_idx = act_q.size();
      exp_idx = exp_q.size();
   endtask

   task automatic check_occ(input string tag);
      @(negedge clk);
      chk({tag, "_empty"}, 64'(wb_empty), 64'(ref_count() == 0));
      chk({tag, "_occ"},   64'(dut.occ_cnt), 64'(ref_count()));
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < 400) begin
         @(negedge clk);
         if (drain_done) got = 1'b1; else n++;
      end
      chk({tag, "_drain_done"}, 64'(got), 64'd1);
   endtask

   // Present a store, wait (bounded) for st_ack, drop the request after the write edge.
   task automatic do_store(input string tag, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] d, output int lat, output logic tv_at_ack);
      bit got = 1'b0;
      @(posedge clk);
      #1;
      st_addr = a;
      st_mbe  = m;
      st_data = d;
      st_req  = 1'b1;
      lat     = 0;
      tv_at_ack = 1'b0;
      while (!got && lat < 400) begin
         @(negedge clk);
         if (st_ack) begin
            got = 1'b1;
            tv_at_ack = wb_tv_in;
         end else begin
            lat++;
         end
      end
      chk({tag, "_ack"}, 64'(got), 64'd1);
      @(posedge clk);
      #1;
      st_req = 1'b0;
      ref_store(a, m, d);
      if (ref_full()) begin
         wait_done({tag, "_auto"});
         ref_drain();
      end
   endtask

   task automatic do_drain(input string tag);
      int extra = 0;
      @(posedge clk);
      #1;
      drain_req = 1'b1;
      wait_done(tag);
      @(posedge clk);
      #1;
      drain_req = 1'b0;
      ref_drain();
      repeat (4) begin
         @(negedge clk);
         if (drain_done) extra++;
      end
      chk({tag, "_extra_done"}, 64'(extra), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_st_ack"},  64'(st_ack), 64'd0);
      chk({tag, "_done"},    64'(drain_done), 64'd0);
      chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
      chk({tag, "_ctl"},     64'({wb_ten, wb_tven, wb_ven, wb_men, wb_rd, wb_wr, wb_fl, wb_tv_in}), 64'd0);
      chk({tag, "_wb_a"},    64'(wb_a), 64'd0);
      chk({tag, "_empty"},   64'(wb_empty), 64'd1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int          lat;
      logic        tv;
      logic [31:0] a;
      logic [31:0] d;
      bit          seen;
      bit          early;
      bit          done_seen;
      int          n;

      rst       = 1'b1;
      st_req    = 1'b0;
      st_addr   = 32'h0;
      st_mbe    = 4'h0;
      st_data   = 32'h0;
      drain_req = 1'b0;
      ack_wait  = 0;
      ref_clear();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // allocate into an empty buffer
      do_store("alloc", 32'h0000_1004, 4'b0011, 32'h1122_3344, lat, tv);
      chk("alloc_latency", 64'(lat), 64'd0);
      chk("alloc_tv_in",   64'(tv), 64'd1);
      check_occ("alloc");

      // merge into the same line
      do_store("merge", 32'h0000_1004, 4'b1100, 32'hAABB_CCDD, lat, tv);
      chk("merge_latency", 64'(lat), 64'd0);
      check_occ("merge");
      check_writes("merge");

      // tag conflict on line 0 evicts word 1 only, then allocates
      ack_wait = 0;
      do_store("evict", 32'h0000_2004, 4'b1111, 32'h5566_7788, lat, tv);
      check_writes("evict");
      check_occ("evict");

      // lines 0 and 2 valid, drain with slow memory
      do_store("line2", 32'h0000_3010, 4'b0101, 32'hCAFE_F00D, lat, tv);
      ack_wait = 3;
      do_drain("drain");
      check_writes("drain");
      check_occ("drain");

      // drain of an empty buffer: full pass, nothing written
      do_drain("drain_empty");
      check_writes("drain_empty");

      // store and drain together: drain first, then store allocates
      ack_wait = 1;
      do_store("pre", 32'h0000_5018, 4'b1111, 32'h0BAD_BEEF, lat, tv);
      @(posedge clk);
      #1;
      st_addr   = 32'h0000_6018;
      st_mbe    = 4'b0110;
      st_data   = 32'h1357_9BDF;
      st_req    = 1'b1;
      drain_req = 1'b1;
      early     = 1'b0;
      done_seen = 1'b0;
      seen      = 1'b0;
      n         = 0;
      while (!seen && n < 400) begin
         @(negedge clk);
         if (st_ack) begin
            seen = 1'b1;
            if (!done_seen) early = 1'b1;
         end
         if (drain_done) done_seen = 1'b1;
         n++;
         @(posedge clk);
         #1;
         if (done_seen) drain_req = 1'b0;
      end
      st_req    = 1'b0;
      drain_req = 1'b0;
      chk("combo_drain_done", 64'(done_seen), 64'd1);
      chk("combo_ack", 64'(seen), 64'd1);
      chk("combo_no_early_ack", 64'(early), 64'd0);
      ref_drain();
      ref_store(32'h0000_6018, 4'b0110, 32'h1357_9BDF);
      check_writes("combo");
      check_occ("combo");

      // reset while a memory write is in flight
      do_drain("pre_rst");
      check_writes("pre_rst");
      do_store("rst_line", 32'h0000_4008, 4'hf, 32'h2468_ACE0, lat, tv);
      ack_wait = 50;
      @(posedge clk);
      #1;
      drain_req = 1'b1;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 50) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1; else n++;
      end
      chk("rst_mw_reached", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      drain_req = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_in_mw");
      chk("rst_in_mw_occ", 64'(dut.occ_cnt), 64'd0);
      rst = 1'b0;
      ref_clear();
      exp_q.delete();
      exp_idx = 0;
      act_idx = act_q.size();

      // random stores and drains over a small tag set to force conflicts
      for (int i = 0; i < 60; i++) begin
         ack_wait = $urandom_range(0, 3);
         if ($urandom_range(0, 6) == 0) begin
            do_drain("rnd_drain");
         end else begin
            a = {27'h100 + 27'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'b00};
            d = $urandom;
            do_store("rnd_store", a, 4'($urandom_range(1, 15)), d, lat, tv);
         end
         check_writes("rnd");
         check_occ("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
